// File: rtl/ee1k_access_ctrl.sv
// Access sequencer and round-robin two-port arbiter for the S018EE1KX16 EEPROM macro (64 x 16).
// Optional write busy-window timeouts are compiled in with EE_WR_TIMEOUT_EN.
module ee1k_access_ctrl #(
  parameter int AW      = 6,
  parameter int DW      = 16,
  parameter int SETUP   = 1,
  parameter int WEN_LOW = 2
`ifdef EE_WR_TIMEOUT_EN
  ,
  parameter logic [19:0] TO_LO = 20'd2048,
  parameter logic [19:0] TO_HI = 20'd40000
`endif
) (
  input  logic          RD_CLK,
  input  logic          RSTN,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          busy,
  output logic [AW-1:0] ee_a,
  output logic [DW-1:0] ee_dbi,
  output logic          ee_cen,
  output logic          ee_oen,
  output logic          ee_wen,
  input  logic [DW-1:0] ee_dbo,
  input  logic          ee_ready
);

  typedef enum logic [3:0] {
    IDLE, RD_ISSUE, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD, WR_WAIT_LO, WR_WAIT_HI, DONE
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP - 1);
  localparam logic [7:0] WEN_LAST   = 8'(WEN_LOW - 1);

  state_t        state_reg, state_next;
  logic          ptr_reg, ptr_next;
  logic          port_reg, port_next;
  logic [7:0]    ph_cnt_reg, ph_cnt_next;
  logic          ready_meta_reg, ready_s_reg;
  logic          gnt0_reg, gnt0_next, gnt1_reg, gnt1_next;
  logic          done0_reg, done0_next, done1_reg, done1_next;
  logic          err_reg, err_next, busy_reg, busy_next;
  logic [DW-1:0] rdata_reg, rdata_next;
  logic [AW-1:0] ee_a_reg, ee_a_next;
  logic [DW-1:0] ee_dbi_reg, ee_dbi_next;
  logic          ee_cen_reg, ee_cen_next, ee_oen_reg, ee_oen_next, ee_wen_reg, ee_wen_next;
`ifdef EE_WR_TIMEOUT_EN
  logic [19:0]   wait_cnt_reg, wait_cnt_next;
`endif

  logic          sel_valid, sel_port, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // With both ports requesting, the pointer names the winner.
  always_comb begin
    sel_valid = req0 | req1;
    sel_port  = (req0 & req1) ? ptr_reg : req1;
    sel_we    = sel_port ? we1 : we0;
    sel_addr  = sel_port ? addr1 : addr0;
    sel_wdata = sel_port ? wdata1 : wdata0;
  end

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    port_next   = port_reg;
    ph_cnt_next = ph_cnt_reg;
    gnt0_next   = 1'b0;
    gnt1_next   = 1'b0;
    done0_next  = 1'b0;
    done1_next  = 1'b0;
    err_next    = err_reg;
    rdata_next  = rdata_reg;
    ee_a_next   = ee_a_reg;
    ee_dbi_next = ee_dbi_reg;
    ee_cen_next = ee_cen_reg;
    ee_oen_next = ee_oen_reg;
    ee_wen_next = ee_wen_reg;
`ifdef EE_WR_TIMEOUT_EN
    wait_cnt_next = wait_cnt_reg;
`endif
    case (state_reg)
      // DONE also arbitrates so a new grant can follow the done cycle directly.
      IDLE, DONE: begin
        state_next = IDLE;
        if (sel_valid) begin
          port_next   = sel_port;
          ptr_next    = ~sel_port;
          gnt0_next   = ~sel_port;
          gnt1_next   = sel_port;
          err_next    = 1'b0;
          ph_cnt_next = 8'd0;
          ee_a_next   = sel_addr;
          ee_cen_next = 1'b0;
          if (sel_we) begin
            ee_dbi_next = sel_wdata;
            ee_wen_next = 1'b1;
            state_next  = WR_SETUP;
          end else begin
            ee_oen_next = 1'b0;
            state_next  = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_next = RD_CAP;
      RD_CAP: begin
        rdata_next  = ee_dbo;
        ee_cen_next = 1'b1;
        ee_oen_next = 1'b1;
        ee_a_next   = '0;
        done0_next  = ~port_reg;
        done1_next  = port_reg;
        state_next  = DONE;
      end
      WR_SETUP: begin
        if (ph_cnt_reg == SETUP_LAST) begin
          ph_cnt_next = 8'd0;
          ee_wen_next = 1'b0;
          state_next  = WR_PULSE;
        end else begin
          ph_cnt_next = ph_cnt_reg + 8'd1;
        end
      end
      WR_PULSE: begin
        if (ph_cnt_reg == WEN_LAST) begin
          ee_wen_next = 1'b1;
          state_next  = WR_HOLD;
        end else begin
          ph_cnt_next = ph_cnt_reg + 8'd1;
        end
      end
      WR_HOLD: begin
        ee_a_next   = '0;
        ee_dbi_next = '0;
        state_next  = WR_WAIT_LO;
`ifdef EE_WR_TIMEOUT_EN
        wait_cnt_next = 20'd0;
`endif
      end
      WR_WAIT_LO: begin
        if (!ready_s_reg) begin
          state_next = WR_WAIT_HI;
`ifdef EE_WR_TIMEOUT_EN
          wait_cnt_next = 20'd0;
        end else if (wait_cnt_reg >= TO_LO) begin
          err_next    = 1'b1;
          ee_cen_next = 1'b1;
          done0_next  = ~port_reg;
          done1_next  = port_reg;
          state_next  = DONE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 20'd1;
`endif
        end
      end
      WR_WAIT_HI: begin
        if (ready_s_reg) begin
          ee_cen_next = 1'b1;
          done0_next  = ~port_reg;
          done1_next  = port_reg;
          state_next  = DONE;
`ifdef EE_WR_TIMEOUT_EN
        end else if (wait_cnt_reg >= TO_HI) begin
          err_next    = 1'b1;
          ee_cen_next = 1'b1;
          done0_next  = ~port_reg;
          done1_next  = port_reg;
          state_next  = DONE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 20'd1;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge RD_CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg      <= IDLE;
      ptr_reg        <= 1'b0;
      port_reg       <= 1'b0;
      ph_cnt_reg     <= 8'd0;
      ready_meta_reg <= 1'b1;
      ready_s_reg    <= 1'b1;
      gnt0_reg       <= 1'b0;
      gnt1_reg       <= 1'b0;
      done0_reg      <= 1'b0;
      done1_reg      <= 1'b0;
      err_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      rdata_reg      <= '0;
      ee_a_reg       <= '0;
      ee_dbi_reg     <= '0;
      ee_cen_reg     <= 1'b1;
      ee_oen_reg     <= 1'b1;
      ee_wen_reg     <= 1'b1;
`ifdef EE_WR_TIMEOUT_EN
      wait_cnt_reg   <= 20'd0;
`endif
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      port_reg       <= port_next;
      ph_cnt_reg     <= ph_cnt_next;
      ready_meta_reg <= ee_ready;
      ready_s_reg    <= ready_meta_reg;
      gnt0_reg       <= gnt0_next;
      gnt1_reg       <= gnt1_next;
      done0_reg      <= done0_next;
      done1_reg      <= done1_next;
      err_reg        <= err_next;
      busy_reg       <= busy_next;
      rdata_reg      <= rdata_next;
      ee_a_reg       <= ee_a_next;
      ee_dbi_reg     <= ee_dbi_next;
      ee_cen_reg     <= ee_cen_next;
      ee_oen_reg     <= ee_oen_next;
      ee_wen_reg     <= ee_wen_next;
`ifdef EE_WR_TIMEOUT_EN
      wait_cnt_reg   <= wait_cnt_next;
`endif
    end
  end

  assign gnt0   = gnt0_reg;
  assign gnt1   = gnt1_reg;
  assign done0  = done0_reg;
  assign done1  = done1_reg;
  assign err    = err_reg;
  assign busy   = busy_reg;
  assign rdata  = rdata_reg;
  assign ee_a   = ee_a_reg;
  assign ee_dbi = ee_dbi_reg;
  assign ee_cen = ee_cen_reg;
  assign ee_oen = ee_oen_reg;
  assign ee_wen = ee_wen_reg;

endmodule
